// File: rtl/fp_cmp_result_stage.sv
// ============================================================================
// Module   : fp_cmp_result_stage
// Purpose  : FP compare result select, invalid status, 2-entry output buffer
// Revision : 1.0
// ============================================================================
`default_nettype none

module fp_cmp_result_stage #(
    parameter int TAGW = 8,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [15:0]     cmp_i,
    input  logic            snan_i,
    input  logic [3:0]      op_i,
    input  logic            signaling_i,
    input  logic [TAGW-1:0] tag_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic            result_o,
    output logic            illegal_o,
    output logic            invalid_o,
    output logic [15:0]     cmp_o,
    output logic [TAGW-1:0] tag_o,
    input  logic            clr_sticky_i,
    output logic            sticky_invalid_o,
    output logic [CNTW-1:0] inv_count_o
);

    localparam int EW = 3 + 16 + TAGW;

    // Entry layout: {result, illegal, invalid, cmp, tag}
    logic [EW-1:0]   head_q, head_d;
    logic [EW-1:0]   spare_q, spare_d;
    logic [1:0]      count_q, count_d;
    logic            sticky_q, sticky_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic            legal;
    logic            invalid;
    logic            push;
    logic            pop;
    logic [EW-1:0]   new_entry;
    logic [CNTW-1:0] cnt_base;

    assign ready_o = (count_q != 2'd2);
    assign valid_o = (count_q != 2'd0);
    assign push    = valid_i & ready_o;
    assign pop     = valid_o & ready_i;

    assign {result_o, illegal_o, invalid_o, cmp_o, tag_o} = head_q;
    assign sticky_invalid_o = sticky_q;
    assign inv_count_o      = cnt_q;

    always_comb begin
        legal     = (op_i <= 4'd4) || ((op_i >= 4'd8) && (op_i <= 4'd12));
        invalid   = snan_i | (signaling_i & cmp_i[4]);
        new_entry = {(legal ? cmp_i[op_i] : 1'b0), ~legal, invalid, cmp_i, tag_i};
    end

    // Head is a dedicated register so an empty buffer keeps showing the
    // last retired entry instead of a stale slot.
    always_comb begin
        head_d  = head_q;
        spare_d = spare_q;
        count_d = count_q;
        if (push && !pop) begin
            if (count_q == 2'd0) begin
                head_d = new_entry;
            end else begin
                spare_d = new_entry;
            end
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            if (count_q == 2'd2) begin
                head_d = spare_q;
            end
            count_d = count_q - 2'd1;
        end else if (push && pop) begin
            // Only reachable at count 1: the new entry replaces the retiring head.
            head_d = new_entry;
        end
    end

    // Clear and a same-cycle invalid accept both apply; the set wins.
    always_comb begin
        cnt_base = clr_sticky_i ? '0 : cnt_q;
        sticky_d = (clr_sticky_i ? 1'b0 : sticky_q) | (push & invalid);
        cnt_d    = cnt_base;
        if (push && invalid && (cnt_base != {CNTW{1'b1}})) begin
            cnt_d = cnt_base + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q   <= '0;
            spare_q  <= '0;
            count_q  <= 2'd0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            head_q   <= head_d;
            spare_q  <= spare_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fp_cmp_result_stage.sv
// ============================================================================
// Module   : tb_fp_cmp_result_stage
// Purpose  : Scoreboard bench for fp_cmp_result_stage
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fp_cmp_result_stage;

    typedef struct packed {
        logic        result;
        logic        illegal;
        logic        invalid;
        logic [15:0] cmp;
        logic [7:0]  tag;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [15:0] cmp_i = '0;
    logic        snan_i = 1'b0;
    logic [3:0]  op_i = '0;
    logic        signaling_i = 1'b0;
    logic [7:0]  tag_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic        result_o;
    logic        illegal_o;
    logic        invalid_o;
    logic [15:0] cmp_o;
    logic [7:0]  tag_o;
    logic        clr_sticky_i = 1'b0;
    logic        sticky_invalid_o;
    logic [15:0] inv_count_o;

    int n_tests = 0;
    int n_fail  = 0;

    ent_t        q[$];
    logic        m_sticky;
    logic [15:0] m_cnt;

    fp_cmp_result_stage #(.TAGW(8), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .cmp_i(cmp_i), .snan_i(snan_i), .op_i(op_i), .signaling_i(signaling_i),
        .tag_i(tag_i), .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
        .illegal_o(illegal_o), .invalid_o(invalid_o), .cmp_o(cmp_o), .tag_o(tag_o),
        .clr_sticky_i(clr_sticky_i), .sticky_invalid_o(sticky_invalid_o),
        .inv_count_o(inv_count_o)
    );

    always #5 clk = ~clk;

    function automatic ent_t model(input logic [15:0] c, input logic sn,
                                   input logic [3:0] op, input logic sg,
                                   input logic [7:0] t);
        ent_t e;
        logic lg;
        lg        = (op <= 4'd4) || ((op >= 4'd8) && (op <= 4'd12));
        e.result  = lg ? c[op] : 1'b0;
        e.illegal = ~lg;
        e.invalid = sn | (sg & c[4]);
        e.cmp     = c;
        e.tag     = t;
        return e;
    endfunction

    // Scoreboard push: reference entry and status model at each accept.
    always @(posedge clk or negedge rst_n) begin
        logic        acc;
        logic        inv;
        logic [15:0] nb;
        if (!rst_n) begin
            q.delete();
            m_sticky = 1'b0;
            m_cnt    = '0;
        end else begin
            acc = valid_i && ready_o;
            inv = snan_i | (signaling_i & cmp_i[4]);
            nb  = clr_sticky_i ? 16'd0 : m_cnt;
            if (acc) q.push_back(model(cmp_i, snan_i, op_i, signaling_i, tag_i));
            m_sticky = (clr_sticky_i ? 1'b0 : m_sticky) | (acc & inv);
            if (acc && inv && nb != 16'hFFFF) nb = nb + 16'd1;
            m_cnt = nb;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] c,
                         input logic sn, input logic sg, input logic [7:0] t);
        valid_i = v; op_i = op; cmp_i = c; snan_i = sn; signaling_i = sg; tag_i = t;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        n_tests++;
        if ({valid_o, result_o, illegal_o, invalid_o, cmp_o, tag_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b res=%b ill=%b inv=%b cmp=%h tag=%h, want all 0",
                     valid_o, result_o, illegal_o, invalid_o, cmp_o, tag_o);
        end
        n_tests++;
        if (sticky_invalid_o !== 1'b0 || inv_count_o !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_status: got sticky=%b cnt=%h, want 0/0000", sticky_invalid_o, inv_count_o);
        end
        rst_n = 1'b1;
        step();
        n_tests++;
        if (ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", ready_o);
        end
    endtask

    task automatic test_single();
        ent_t e;
        ready_i = 1'b1;
        drive(1'b1, 4'd1, 16'h1606, 1'b0, 1'b0, 8'h5A);
        step();
        drive(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 8'h00);
        n_tests++;
        if (valid_o !== 1'b1 || q.size() == 0) begin
            n_fail++;
            $display("FAIL single_valid: got valid=%b qsize=%0d, want 1/1", valid_o, q.size());
        end else begin
            e = q.pop_front();
            if ({result_o, illegal_o, invalid_o, cmp_o, tag_o} !== e || e.result !== 1'b1 || e.tag !== 8'h5A) begin
                n_fail++;
                $display("FAIL single_entry: got %h want %h (res 1 tag 5A)",
                         {result_o, illegal_o, invalid_o, cmp_o, tag_o}, e);
            end
        end
        step();
        n_tests++;
        if (valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drop: got valid=%b want 0", valid_o);
        end
    endtask

    task automatic test_back_to_back();
        ent_t e;
        ready_i = 1'b0;
        drive(1'b1, 4'd0, 16'h1301, 1'b0, 1'b0, 8'h01);
        step();
        drive(1'b1, 4'd10, 16'h1606, 1'b0, 1'b0, 8'h02);
        step();
        n_tests++;
        if (ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_full: got ready_o=%b want 0", ready_o);
        end
        drive(1'b1, 4'd2, 16'h1606, 1'b0, 1'b0, 8'h03);
        step(); step();
        n_tests++;
        if (ready_o !== 1'b0 || valid_o !== 1'b1 || tag_o !== 8'h01) begin
            n_fail++;
            $display("FAIL b2b_hold: got ready=%b valid=%b tag=%h, want 0/1/01", ready_o, valid_o, tag_o);
        end
        drive(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 8'h00);
        ready_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (valid_o !== 1'b1 || q.size() == 0) begin
                n_fail++;
                $display("FAIL b2b_drain%0d: got valid=%b qsize=%0d", i, valid_o, q.size());
            end else begin
                e = q.pop_front();
                if ({result_o, illegal_o, invalid_o, cmp_o, tag_o} !== e || tag_o !== 8'(i + 1)) begin
                    n_fail++;
                    $display("FAIL b2b_drain%0d: got %h want %h", i,
                             {result_o, illegal_o, invalid_o, cmp_o, tag_o}, e);
                end
            end
            step();
            if (i == 0) begin
                n_tests++;
                if (ready_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_ready_back: got %b want 1", ready_o);
                end
            end
        end
        n_tests++;
        if (valid_o !== 1'b0 || q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_empty: got valid=%b qsize=%0d, want 0/0", valid_o, q.size());
        end
    endtask

    task automatic test_unordered(input logic sg, input logic [15:0] want_cnt);
        ent_t e;
        ready_i = 1'b1;
        drive(1'b1, 4'd4, 16'h0110, 1'b0, sg, 8'h40);
        step();
        drive(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 8'h00);
        n_tests++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unord_sig%0b: no entry accepted", sg);
        end else begin
            e = q.pop_front();
            if (valid_o !== 1'b1 || {result_o, illegal_o, invalid_o, cmp_o, tag_o} !== e
                || result_o !== 1'b1 || invalid_o !== sg) begin
                n_fail++;
                $display("FAIL unord_sig%0b: got v=%b %h want %h (res 1 inv %b)", sg, valid_o,
                         {result_o, illegal_o, invalid_o, cmp_o, tag_o}, e, sg);
            end
        end
        n_tests++;
        if (sticky_invalid_o !== sg || inv_count_o !== want_cnt) begin
            n_fail++;
            $display("FAIL unord_status%0b: got sticky=%b cnt=%h want %b/%h", sg,
                     sticky_invalid_o, inv_count_o, sg, want_cnt);
        end
        step();
    endtask

    task automatic test_reserved();
        ent_t e;
        ready_i = 1'b1;
        drive(1'b1, 4'd5, 16'h1606, 1'b1, 1'b0, 8'h55);
        step();
        drive(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 8'h00);
        n_tests++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL reserved: no entry accepted");
        end else begin
            e = q.pop_front();
            if ({result_o, illegal_o, invalid_o, cmp_o, tag_o} !== e
                || {result_o, illegal_o, invalid_o} !== 3'b011) begin
                n_fail++;
                $display("FAIL reserved: got %h want %h (res0 ill1 inv1)",
                         {result_o, illegal_o, invalid_o, cmp_o, tag_o}, e);
            end
        end
        n_tests++;
        if (inv_count_o !== 16'd2 || sticky_invalid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reserved_status: got cnt=%h sticky=%b want 0002/1", inv_count_o, sticky_invalid_o);
        end
        step();
    endtask

    task automatic test_saturate();
        ent_t e;
        int   bad = 0;
        ready_i = 1'b1;
        clr_sticky_i = 1'b1;
        step();
        clr_sticky_i = 1'b0;
        n_tests++;
        if (sticky_invalid_o !== 1'b0 || inv_count_o !== 16'h0) begin
            n_fail++;
            $display("FAIL clear: got sticky=%b cnt=%h want 0/0000", sticky_invalid_o, inv_count_o);
        end
        // Stream invalid requests at full rate; each retires the cycle after accept.
        for (int i = 0; i < 16'hFFFE + 3; i++) begin
            drive(1'b1, 4'(i % 13), 16'h1010, 1'b1, 1'b0, 8'(i));
            step();
            if (i == 16'hFFFD) begin
                n_tests++;
                if (inv_count_o !== 16'hFFFE) begin
                    n_fail++;
                    $display("FAIL preload: got cnt=%h want FFFE", inv_count_o);
                end
            end
            if (q.size() == 0 || valid_o !== 1'b1) begin
                bad++;
            end else begin
                e = q.pop_front();
                if ({result_o, illegal_o, invalid_o, cmp_o, tag_o} !== e) bad++;
            end
        end
        drive(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 8'h00);
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stream: %0d entries wrong or missing, want 0", bad);
        end
        n_tests++;
        if (inv_count_o !== 16'hFFFF || inv_count_o !== m_cnt) begin
            n_fail++;
            $display("FAIL saturate: got cnt=%h want FFFF", inv_count_o);
        end
        step();
        clr_sticky_i = 1'b1;
        drive(1'b1, 4'd0, 16'h0000, 1'b1, 1'b0, 8'h77);
        step();
        clr_sticky_i = 1'b0;
        drive(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 8'h00);
        n_tests++;
        if (sticky_invalid_o !== 1'b1 || inv_count_o !== 16'd1) begin
            n_fail++;
            $display("FAIL clr_and_set: got sticky=%b cnt=%h want 1/0001", sticky_invalid_o, inv_count_o);
        end
        if (q.size() != 0) void'(q.pop_front());
        step();
    endtask

    task automatic test_reset_mid();
        ent_t e;
        ready_i = 1'b0;
        drive(1'b1, 4'd1, 16'h1606, 1'b1, 1'b0, 8'hA1);
        step();
        drive(1'b1, 4'd9, 16'h1606, 1'b0, 1'b0, 8'hA2);
        step();
        drive(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 8'h00);
        n_tests++;
        if (ready_o !== 1'b0 || sticky_invalid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_full: got ready=%b sticky=%b want 0/1", ready_o, sticky_invalid_o);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (valid_o !== 1'b0 || inv_count_o !== 16'h0 || sticky_invalid_o !== 1'b0 || tag_o !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset: got valid=%b cnt=%h sticky=%b tag=%h want 0/0000/0/00",
                     valid_o, inv_count_o, sticky_invalid_o, tag_o);
        end
        #1;
        rst_n = 1'b1;
        step();
        ready_i = 1'b1;
        drive(1'b1, 4'd12, 16'h1606, 1'b0, 1'b0, 8'h33);
        step();
        drive(1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 8'h00);
        n_tests++;
        if (valid_o !== 1'b1 || q.size() != 1) begin
            n_fail++;
            $display("FAIL post_reset: got valid=%b qsize=%0d want 1/1", valid_o, q.size());
        end else begin
            e = q.pop_front();
            if ({result_o, illegal_o, invalid_o, cmp_o, tag_o} !== e || tag_o !== 8'h33) begin
                n_fail++;
                $display("FAIL post_reset: got %h want %h",
                         {result_o, illegal_o, invalid_o, cmp_o, tag_o}, e);
            end
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_unordered(1'b0, 16'd0);
        test_unordered(1'b1, 16'd1);
        test_reserved();
        test_saturate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fp_cmp_result_stage.md
Name: fp_cmp_result_stage

Overview:
- Registered stage directly downstream of the 64-bit FP compare unit.
- Takes the 16-bit compare vector plus the signalling-NaN flag and selects one predicate bit per request by opcode.
- Computes the per-op invalid exception and keeps a sticky invalid flag and a saturating invalid-event counter for the FP status register.
- Decouples the comparator from the consumer (branch/set-condition logic) with a 2-entry valid/ready output buffer.

Parameters:
- TAGW, 8, width of the tag carried alongside each request (ROB/dest id).
- CNTW, 16, width of the saturating invalid-event counter.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_i  in  1  request valid.
- ready_o  out  1  stage can accept; a transfer happens when valid_i & ready_o.
- cmp_i  in  16  comparator vector. Bit meanings:
  - 0 eq, 1 lt, 2 le, 3 magnitude lt, 4 unordered
  - 8 ne, 9 ge, 10 gt, 11 magnitude ge, 12 ordered
  - 5-7 and 13-15 are zero
- snan_i  in  1  either operand is a signalling NaN.
- op_i  in  4  predicate select (index into cmp_i).
- signaling_i  in  1  1 = signalling compare: any unordered operand raises invalid.
- tag_i  in  TAGW  request tag.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer ready; a transfer happens when valid_o & ready_i.
- result_o  out  1  selected predicate.
- illegal_o  out  1  op was a reserved code.
- invalid_o  out  1  this result raised invalid.
- cmp_o  out  16  registered copy of cmp_i.
- tag_o  out  TAGW  registered tag.
- clr_sticky_i  in  1  clear sticky flag and counter.
- sticky_invalid_o  out  1  sticky invalid flag.
- inv_count_o  out  CNTW  saturating count of accepted requests with invalid=1.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Buffer count = 0; valid_o = 0.
  - result_o, illegal_o, invalid_o, cmp_o, tag_o = 0.
  - sticky_invalid_o = 0; inv_count_o = 0.
  - ready_o = 1 once rst_n rises; no transfer is taken while rst_n is low.
  - Reset mid-operation discards all buffered entries.
- Entry computation at accept, purely from the inputs:
  - legal = op_i in {0..4, 8..12}.
  - result = legal ? cmp_i[op_i] : 0.
  - illegal = ~legal.
  - invalid = snan_i | (signaling_i & cmp_i[4]).
  - Reserved ops still compute invalid normally.
- Buffer:
  - 2-entry FIFO of {result, illegal, invalid, cmp, tag}.
  - Head drives the outputs; valid_o = (count != 0); ready_o = (count != 2). Both come from registered state, with no combinational path from ready_i to ready_o.
  - Latency: an accepted request appears on the outputs the next cycle when the buffer was empty, or behind the older entry otherwise.
  - Throughput: 1 request per cycle while ready_i = 1.
  - Push with no pop: count+1. Pop with no push: count-1. Push and pop in the same cycle: count unchanged, order preserved. The push/pop case is legal at count 1, and at count 2 only as a pop (ready_o = 0).
  - Full (count 2): ready_o = 0; valid_i is ignored.
  - Empty: output fields hold their last values, but valid_o = 0.
  - Output fields stay stable while valid_o & ~ready_i.
- Status:
  - Updated at accept time, not at retirement.
  - sticky_invalid next = (clr_sticky_i ? 0 : sticky) | (accept & invalid).
  - inv_count next = (clr_sticky_i ? 0 : count) + (accept & invalid), saturating at all-ones (no wrap).
  - A clear and an invalid accept in the same cycle give sticky = 1 and count = 1; set wins, so no event is lost.

Test Plan:
- Reset, then a single request with op=1, cmp_i=16'h1606 (lt, le, ge... as driven), tag=8'h5A, ready_i=1 -> next cycle valid_o=1, result_o=1, tag_o=5A, invalid_o=0; valid_o drops the following cycle.
- Back-to-back requests with ready_i held 0 -> ready_o falls after the 2nd accept and the 3rd request is held off. Then raise ready_i -> outputs drain in order (tags 01, 02), and ready_o returns to 1 in the first pop cycle.
- op=4, cmp_i[4]=1, signaling_i=0, snan_i=0 -> result_o=1, invalid_o=0. Same with signaling_i=1 -> invalid_o=1, sticky_invalid_o=1, inv_count_o=1.
- op=5 (reserved) with snan_i=1 -> result_o=0, illegal_o=1, invalid_o=1.
- inv_count preloaded to 16'hFFFE by 0xFFFE invalid requests, then 3 more -> inv_count_o=FFFF, no wrap. Then clr_sticky_i coincident with an invalid accept -> sticky=1, count=1.
- rst_n asserted low while count=2 -> valid_o=0 immediately, inv_count_o=0, sticky=0. The first post-reset request is delivered with 1-cycle latency.
